// File: rtl/speed_pwm_pkg.sv
// Shared types and constants for the speed PWM driver: slew FSM states,
// duty width and the three duty levels requested by the ramp-start FSM.
package speed_pwm_pkg;

  localparam int DUTY_W = 7;

  localparam logic [DUTY_W-1:0] DUTY_0   = 7'd0;
  localparam logic [DUTY_W-1:0] DUTY_30  = 7'd30;
  localparam logic [DUTY_W-1:0] DUTY_50  = 7'd50;
  localparam logic [DUTY_W-1:0] DUTY_100 = 7'd100;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN,
    HOLD
  } state_e;

  // Highest asserted level wins; a deasserted enable forces the target to 0.
  function automatic logic [DUTY_W-1:0] decode_target(
    input logic en,
    input logic l30,
    input logic l50,
    input logic l100
  );
    if (!en)       return DUTY_0;
    else if (l100) return DUTY_100;
    else if (l50)  return DUTY_50;
    else if (l30)  return DUTY_30;
    else           return DUTY_0;
  endfunction

endpackage

// File: rtl/speed_pwm_driver_pwm_core.sv
// PWM generator: period counter, period-boundary duty shadow and registered
// comparator. With SPEED_PWM_FAST_STOP_EN a stop input clears the shadow at once.
module pwm_core
  import speed_pwm_pkg::*;
#(
  parameter int PWM_STEPS = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] duty_cur,
`ifdef SPEED_PWM_FAST_STOP_EN
  input  logic              stop,
`endif
  output logic              pwm_out
);

  localparam int CNT_W = (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;
  localparam int CMP_W = (CNT_W > DUTY_W) ? CNT_W : DUTY_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_STEPS - 1);

  logic [CNT_W-1:0]  pwm_cnt;
  logic [DUTY_W-1:0] duty_applied;
  logic              period_end;
  logic [CMP_W-1:0]  cnt_x;
  logic [CMP_W-1:0]  duty_x;

  assign period_end = (pwm_cnt == CNT_LAST);
  assign cnt_x      = CMP_W'(pwm_cnt);
  assign duty_x     = CMP_W'(duty_applied);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let pwm_out see the new shadow early.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt      <= '0;
      duty_applied <= '0;
      pwm_out      <= 1'b0;
    end else begin
      pwm_cnt <= period_end ? '0 : pwm_cnt + 1'b1;
      // Full duty keeps every count below duty_applied, so no wrap glitch.
      pwm_out <= (cnt_x < duty_x);
`ifdef SPEED_PWM_FAST_STOP_EN
      if (stop)            duty_applied <= '0;
      else if (period_end) duty_applied <= duty_cur;
`else
      if (period_end)      duty_applied <= duty_cur;
`endif
    end
  end

endmodule

// File: rtl/speed_pwm_driver.sv
// Slewed-duty motor PWM driver fed by the ramp-start FSM's one-hot levels.
// Optional macro SPEED_PWM_FAST_STOP_EN: a zero target clears the duty at once.
module speed_pwm_driver
  import speed_pwm_pkg::*;
#(
  parameter int PWM_STEPS = 100,
  parameter int SLEW_DIV  = 1000,
  parameter int SLEW_W    = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lvl_30,
  input  logic              lvl_50,
  input  logic              lvl_100,
  input  logic              enable,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty_cur,
  output logic              at_target,
  output logic              lvl_err
);

  logic [SLEW_W-1:0] slew_cnt;
  logic              slew_tick;
  logic [DUTY_W-1:0] target;
  logic              multi_lvl;
  logic              go_up;
  logic              go_down;
  logic [DUTY_W-1:0] duty_nxt;
  state_e            state;
  state_e            state_nxt;
`ifdef SPEED_PWM_FAST_STOP_EN
  logic              fast_stop;
`endif

  assign target    = decode_target(enable, lvl_30, lvl_50, lvl_100);
  assign multi_lvl = (lvl_30 & lvl_50) | (lvl_30 & lvl_100) | (lvl_50 & lvl_100);
  assign slew_tick = (slew_cnt == SLEW_W'(SLEW_DIV - 1));
  assign go_up     = (target > duty_cur);
  assign go_down   = (target < duty_cur);

  // Prescaler free-runs in every state so the step rate never drifts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) slew_cnt <= '0;
    else        slew_cnt <= slew_tick ? '0 : slew_cnt + 1'b1;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    duty_nxt  = duty_cur;
    state_nxt = state;
`ifdef SPEED_PWM_FAST_STOP_EN
    fast_stop = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (go_up) state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        if (go_down) begin
          state_nxt = RAMP_DOWN;
        end else if (!go_up) begin
          state_nxt = (target == DUTY_0) ? IDLE : HOLD;
        end else if (slew_tick && duty_cur < DUTY_100) begin
          duty_nxt = duty_cur + 1'b1;
          if (duty_nxt == target) state_nxt = HOLD;
        end
      end
      RAMP_DOWN: begin
        if (go_up) begin
          state_nxt = RAMP_UP;
        end else if (!go_down) begin
          state_nxt = (target == DUTY_0) ? IDLE : HOLD;
        end else if (slew_tick && duty_cur != DUTY_0) begin
          duty_nxt = duty_cur - 1'b1;
          if (duty_nxt == target) state_nxt = (target == DUTY_0) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (go_up)        state_nxt = RAMP_UP;
        else if (go_down) state_nxt = RAMP_DOWN;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef SPEED_PWM_FAST_STOP_EN
    if (target == DUTY_0 && state != IDLE) begin
      fast_stop = 1'b1;
      duty_nxt  = DUTY_0;
      state_nxt = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      duty_cur  <= DUTY_0;
      at_target <= 1'b1;
      lvl_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      duty_cur  <= duty_nxt;
      at_target <= (duty_cur == target);
      lvl_err   <= multi_lvl;
    end
  end

  pwm_core #(
    .PWM_STEPS (PWM_STEPS)
  ) u_pwm_core (
    .clk      (clk),
    .reset    (reset),
    .duty_cur (duty_cur),
`ifdef SPEED_PWM_FAST_STOP_EN
    .stop     (fast_stop),
`endif
    .pwm_out  (pwm_out)
  );

endmodule

// File: tb/tb_speed_pwm_driver.sv
// Self-checking bench for speed_pwm_driver: a cycle model built from the duty
// rules is compared every cycle, plus hand-computed checkpoints.
module tb_speed_pwm_driver;

  localparam int SD = 4;
  localparam int PS = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lvl_30 = 1'b0;
  logic       lvl_50 = 1'b0;
  logic       lvl_100 = 1'b0;
  logic       enable = 1'b0;
  logic       pwm_out;
  logic [6:0] duty_cur;
  logic       at_target;
  logic       lvl_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  speed_pwm_driver #(
    .PWM_STEPS (PS),
    .SLEW_DIV  (SD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .lvl_30    (lvl_30),
    .lvl_50    (lvl_50),
    .lvl_100   (lvl_100),
    .enable    (enable),
    .pwm_out   (pwm_out),
    .duty_cur  (duty_cur),
    .at_target (at_target),
    .lvl_err   (lvl_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int target_of(input logic en, input logic l30, input logic l50, input logic l100);
    if (!en)  return 0;
    if (l100) return 100;
    if (l50)  return 50;
    if (l30)  return 30;
    return 0;
  endfunction

  function automatic int toward(input int d, input int t);
    if (t > d) return d + 1;
    if (t < d) return d - 1;
    return d;
  endfunction

  // Model: m_k clocks since reset; slew steps land on every SD-th clock, the
  // applied duty is captured on the last clock of each PS-clock period.
  int m_k       = 0;
  int m_duty    = 0;
  int m_applied = 0;
  bit m_pwm     = 1'b0;
  bit m_at      = 1'b1;
  bit m_err     = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_k       <= 0;
      m_duty    <= 0;
      m_applied <= 0;
      m_pwm     <= 1'b0;
      m_at      <= 1'b1;
      m_err     <= 1'b0;
    end else begin
      m_pwm <= ((m_k % PS) < m_applied);
      if ((m_k % PS) == PS - 1) m_applied <= m_duty;
      m_at  <= (m_duty == target_of(enable, lvl_30, lvl_50, lvl_100));
      m_err <= ((int'(lvl_30) + int'(lvl_50) + int'(lvl_100)) >= 2);
      if ((m_k % SD) == SD - 1) m_duty <= toward(m_duty, target_of(enable, lvl_30, lvl_50, lvl_100));
`ifdef SPEED_PWM_FAST_STOP_EN
      if (target_of(enable, lvl_30, lvl_50, lvl_100) == 0 && m_duty != 0) begin
        m_duty    <= 0;
        m_applied <= 0;
      end
`endif
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("cyc_duty_cur", 32'(duty_cur), 32'(m_duty));
      check("cyc_at_target", 32'(at_target), 32'(m_at));
      check("cyc_lvl_err", 32'(lvl_err), 32'(m_err));
      check("cyc_pwm_out", 32'(pwm_out), 32'(m_pwm));
    end
  end

  // Align input changes to the clock right after a slew step.
  task automatic wait_phase0();
    for (int i = 0; i < 2 * SD && (m_k % SD) != 0; i++) @(negedge clk);
    check("phase_align", 32'(m_k % SD), 32'd0);
  endtask

  task automatic wait_duty(input int val, input int budget, input string name);
    for (int i = 0; i < budget && m_duty != val; i++) @(negedge clk);
    check(name, 32'(duty_cur), 32'(val));
  endtask

  task automatic count_highs(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) hi++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_duty_cur", 32'(duty_cur), 32'd0);
    check("rst_at_target", 32'(at_target), 32'd1);
    check("rst_pwm_out", 32'(pwm_out), 32'd0);
    check("rst_lvl_err", 32'(lvl_err), 32'd0);
    reset  = 1'b1;
    enable = 1'b1;

    // Ten idle periods: no levels, gate stays low.
    count_highs(10 * PS, hi);
    check("idle_pwm_highs", 32'(hi), 32'd0);
    check("idle_duty_cur", 32'(duty_cur), 32'd0);

    // Ramp to 30 %: one step per SD clocks, 30 steps.
    wait_phase0();
    lvl_30 = 1'b1;
    repeat (30 * SD - 1) @(negedge clk);
    check("ramp30_minus1", 32'(duty_cur), 32'd29);
    @(negedge clk);
    check("ramp30_reached", 32'(duty_cur), 32'd30);
    check("ramp30_at_lag", 32'(at_target), 32'd0);
    @(negedge clk);
    check("ramp30_at_target", 32'(at_target), 32'd1);
    repeat (2 * PS) @(negedge clk);
    count_highs(PS, hi);
    check("pwm30_highs", 32'(hi), 32'd30);

    // Head for 100 %, redirect to 50 % at duty 70.
    wait_phase0();
    lvl_30  = 1'b0;
    lvl_100 = 1'b1;
    wait_duty(70, 400, "up_to_70");
    wait_phase0();
    lvl_100 = 1'b0;
    lvl_50  = 1'b1;
    repeat (20 * SD - 1) @(negedge clk);
    check("down50_minus1", 32'(duty_cur), 32'd51);
    @(negedge clk);
    check("down50_reached", 32'(duty_cur), 32'd50);
    repeat (2) @(negedge clk);
    check("hold50_at_target", 32'(at_target), 32'd1);

    // Two levels at once: 100 wins, lvl_err registered and not sticky.
    wait_phase0();
    lvl_50  = 1'b0;
    lvl_30  = 1'b1;
    lvl_100 = 1'b1;
    @(negedge clk);
    check("err_set", 32'(lvl_err), 32'd1);
    lvl_30 = 1'b0;
    @(negedge clk);
    check("err_clear", 32'(lvl_err), 32'd0);
    wait_duty(100, 300 * SD, "up_to_100");
    repeat (2 * PS) @(negedge clk);
    count_highs(2 * PS, hi);
    check("pwm100_highs", 32'(hi), 32'(2 * PS));

    // Disable at full duty.
    wait_phase0();
    enable = 1'b0;
`ifdef SPEED_PWM_FAST_STOP_EN
    @(negedge clk);
    check("fast_stop_duty", 32'(duty_cur), 32'd0);
    @(negedge clk);
    check("fast_stop_pwm", 32'(pwm_out), 32'd0);
`else
    repeat (100 * SD - 1) @(negedge clk);
    check("stop_minus1", 32'(duty_cur), 32'd1);
    @(negedge clk);
    check("stop_reached", 32'(duty_cur), 32'd0);
`endif
    repeat (2) @(negedge clk);
    check("stop_at_target", 32'(at_target), 32'd1);
    repeat (2 * PS) @(negedge clk);
    check("stop_pwm_low", 32'(pwm_out), 32'd0);

    // Reset mid-period at duty 50.
    wait_phase0();
    enable  = 1'b1;
    lvl_100 = 1'b0;
    lvl_50  = 1'b1;
    wait_duty(50, 100 * SD, "up_to_50_again");
    for (int i = 0; i < 3 * PS && pwm_out !== 1'b1; i++) @(negedge clk);
    check("pwm_high_before_reset", 32'(pwm_out), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_pwm_low", 32'(pwm_out), 32'd0);
    check("async_duty_cur", 32'(duty_cur), 32'd0);
    check("async_at_target", 32'(at_target), 32'd1);
    check("async_lvl_err", 32'(lvl_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (SD - 1) @(negedge clk);
    check("restart_hold0", 32'(duty_cur), 32'd0);
    @(negedge clk);
    check("restart_step1", 32'(duty_cur), 32'd1);
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/speed_pwm_driver.md
Name: speed_pwm_driver

Overview:
- Downstream stage of the ramp-start FSM: consumes its one-hot speed levels (30 %, 50 %, 100 %) and drives the motor gate with a glitch-free PWM.
- Duty slews toward the requested level at a fixed rate, which softens the FSM's step changes.
- Runs on the full system clock, not the prescaled 1 Hz clock.

Parameters:
- PWM_STEPS, 100, PWM counts per period; duty is in percent, so the PWM frequency is clk/100.
- SLEW_DIV, 1000, clocks per 1 % duty step (legal range ≥1).
- SLEW_W, $clog2(SLEW_DIV), width of the slew prescaler counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- lvl_30  input  1  speed request 30 %, from the ramp FSM.
- lvl_50  input  1  speed request 50 %.
- lvl_100  input  1  speed request 100 %.
- enable  input  1  0 forces a ramp-down to 0 %.
- pwm_out  output  1  motor gate drive.
- duty_cur  output  7  current slewed duty, 0..100.
- at_target  output  1  duty_cur equals the target.
- lvl_err  output  1  more than one level request asserted (registered).

Behaviour:
- Reset (reset=0, async) clears:
  - duty_cur=0, duty_applied=0, pwm_cnt=0, slew_cnt=0.
  - pwm_out=0, lvl_err=0, at_target=1, state=IDLE.
- Target decode (combinational):
  - enable=0 or no level asserted → 0.
  - Otherwise the highest asserted level wins: 100 > 50 > 30.
  - lvl_err is registered, high the cycle after any two or more lvl_* inputs are high together; it is not sticky.
- Slew prescaler:
  - slew_cnt counts 0..SLEW_DIV-1 and wraps.
  - slew_tick is asserted when slew_cnt==SLEW_DIV-1.
  - The counter free-runs in all states.
- FSM states: IDLE, RAMP_UP, RAMP_DOWN, HOLD.
  - IDLE: duty_cur=0. target>0 → RAMP_UP.
  - RAMP_UP: on slew_tick, duty_cur+=1. On reaching target → HOLD. If target<duty_cur → RAMP_DOWN.
  - RAMP_DOWN: on slew_tick, duty_cur-=1. duty_cur==target → HOLD, or IDLE if target==0. If target>duty_cur → RAMP_UP.
  - HOLD: target>duty_cur → RAMP_UP. target<duty_cur → RAMP_DOWN.
  - A target change mid-ramp takes effect on the next cycle; duty_cur is never reset by a target change.
- Duty arithmetic:
  - duty_cur is saturated to 0..100 and never over- or undershoots the target.
  - at_target=(duty_cur==target), registered.
- PWM:
  - pwm_cnt counts 0..PWM_STEPS-1 and wraps.
  - duty_applied loads duty_cur only when pwm_cnt==PWM_STEPS-1, so duty changes only at period boundaries.
  - pwm_out is registered: pwm_out=(pwm_cnt<duty_applied). This gives 1 cycle latency from the counter to the pin.
  - duty 0 → constant low. Duty 100 → constant high, with no glitch across the wrap.
- Reset mid-ramp: immediate return to reset values; pwm_out drops asynchronously.

Optional Feature:
- Macro SPEED_PWM_FAST_STOP_EN.
- Defined: when target becomes 0, duty_cur and duty_applied clear to 0 on the next clock (bypassing the slew and the period boundary) and the FSM enters IDLE.
- Undefined: a transition to 0 ramps down normally at the SLEW_DIV rate.

Decomposition:
- Package speed_pwm_pkg holds:
  - The state enum (IDLE, RAMP_UP, RAMP_DOWN, HOLD).
  - Constants DUTY_30=7'd30, DUTY_50=7'd50, DUTY_100=7'd100, DUTY_W=7.
- One sub-module, pwm_core: the period counter, duty_applied shadow register and comparator. Its inputs are duty_cur and clk/reset; its output is pwm_out.
- The slew FSM stays in the top.

Test Plan:
- Reset low then high, no levels → pwm_out=0, duty_cur=0, at_target=1, state IDLE for 10 periods.
- SLEW_DIV=4, lvl_30=1 → duty_cur increments every 4 clocks; reaches 30 after 120 clocks; at_target=1; pwm_out high for 30 of every 100 clocks once applied.
- Set lvl_100, then drop to lvl_50 at duty 70 → duty_cur decreases and settles at 50 (HOLD). No duty_applied change except at pwm_cnt==99.
- lvl_30=lvl_100=1 → target 100, lvl_err=1 one cycle later, clears one cycle after lvl_30 drops.
- At duty 100, enable=0 → without the macro, ramp to 0 in 100×SLEW_DIV clocks and end in IDLE. With SPEED_PWM_FAST_STOP_EN, duty_cur=0 and pwm_out=0 within 2 clocks.
- Assert reset mid-period at duty 50 → pwm_out low immediately (async); all outputs at reset values; after release, ramp restarts from 0.
